// File: rtl/jtvigil_pcm_mc.sv
// Multi-channel PCM sample fetcher: per-channel ROM pointers with manual or
// rate-driven stepping, sharing one PCM ROM port through a round-robin fetch FSM.
module jtvigil_pcm_mc #(
    parameter int         CH       = 2,
    parameter int         AW       = 16,
    parameter int         DW       = 8,
    parameter logic [7:0] END_CODE = 8'h80
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cen,
    input  logic                   cpu_wr,
    input  logic                   cpu_rd,
    input  logic [$clog2(CH)+1:0]  cpu_addr,
    input  logic [7:0]             cpu_din,
    output logic [DW-1:0]          cpu_dout,
    output logic                   rom_cs,
    output logic [AW-1:0]          rom_addr,
    input  logic [DW-1:0]          rom_data,
    input  logic                   rom_ok,
    output logic [CH*DW-1:0]       snd_ch,
    output logic [CH-1:0]          sample,
    output logic [CH-1:0]          running
);

    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t        st;
    logic [AW-1:0] ptr  [CH];
    logic [3:0]    rate [CH];
    logic [3:0]    pre  [CH];
    logic [DW-1:0] smp  [CH];
    logic [CH-1:0] run, autom, stop, pend;
    logic [CHW-1:0] sel, rr, nxt_sel, scan, ch_a;
    logic [1:0]    reg_a;
    logic          found, wr_q, ptr_hit, ch_ok, wr_edge, ptr_wr, hit_now;

    generate
        if (CH > 1) begin : g_multi
            assign ch_a = cpu_addr[CHW+1:2];
        end else begin : g_single
            assign ch_a = '0;
        end
    endgenerate

    assign reg_a   = cpu_addr[1:0];
    assign ch_ok   = (int'(ch_a) < CH);
    assign wr_edge = cpu_wr & ~wr_q;
    assign ptr_wr  = wr_edge & ch_ok & ~reg_a[1];
    // A pointer write to the channel being fetched overrides the post-capture increment
    assign hit_now = ptr_wr && ((st == IDLE) ? (found && ch_a == nxt_sel) : (ch_a == sel));

    always_comb begin
        found   = 1'b0;
        nxt_sel = '0;
        scan    = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            scan = CHW'((int'(rr) + k) % CH);
            if (pend[scan]) begin
                found   = 1'b1;
                nxt_sel = scan;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            sel      <= '0;
            rr       <= '0;
            pend     <= '0;
            run      <= '0;
            autom    <= '0;
            stop     <= '0;
            wr_q     <= 1'b0;
            ptr_hit  <= 1'b0;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            sample   <= '0;
            cpu_dout <= '0;
            for (int i = 0; i < CH; i++) begin
                ptr[i]  <= '0;
                rate[i] <= '0;
                pre[i]  <= '0;
                smp[i]  <= '0;
            end
        end else begin
            wr_q   <= cpu_wr;
            sample <= '0;
            if (cpu_rd) cpu_dout <= ch_ok ? smp[ch_a] : '0;

            case (st)
                IDLE: if (found) begin
                    sel      <= nxt_sel;
                    rr       <= CHW'((int'(nxt_sel) + 1) % CH);
                    rom_cs   <= 1'b1;
                    rom_addr <= ptr[nxt_sel];
                    ptr_hit  <= hit_now;
                    st       <= REQ;
                end
                REQ: begin
                    if (hit_now) ptr_hit <= 1'b1;
                    st <= WAIT;
                end
                WAIT: begin
                    if (hit_now) ptr_hit <= 1'b1;
                    if (rom_ok) begin
                        pend[sel] <= 1'b0;
                        rom_cs    <= 1'b0;
                        st        <= IDLE;
                        if (stop[sel] && rom_data[7:0] == END_CODE) begin
                            run[sel] <= 1'b0;
                        end else begin
                            smp[sel]    <= rom_data;
                            sample[sel] <= 1'b1;
                            if (!ptr_hit && !hit_now) ptr[sel] <= ptr[sel] + 1'b1;
                        end
                    end
                end
                default: st <= IDLE;
            endcase

            // Set after the capture clear so a step landing on a capture is kept
            for (int i = 0; i < CH; i++) begin
                if (cen && run[i] && autom[i]) begin
                    if (pre[i] == rate[i]) begin
                        pre[i]  <= '0;
                        pend[i] <= 1'b1;
                    end else begin
                        pre[i] <= pre[i] + 4'd1;
                    end
                end
            end

            if (wr_edge && ch_ok) begin
                case (reg_a)
                    2'd0: ptr[ch_a][7:0] <= cpu_din;
                    2'd1: ptr[ch_a][AW-1:8] <= (AW-8)'(cpu_din);
                    2'd2: begin
                        run[ch_a]   <= cpu_din[0];
                        autom[ch_a] <= cpu_din[1];
                        stop[ch_a]  <= cpu_din[2];
                        rate[ch_a]  <= cpu_din[7:4];
                        pre[ch_a]   <= '0;
                        if (!cpu_din[0]) pend[ch_a] <= 1'b0;
                    end
                    default: if (run[ch_a] && !autom[ch_a]) pend[ch_a] <= 1'b1;
                endcase
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_out
        assign snd_ch[g*DW +: DW] = smp[g];
    end
    assign running = run;

endmodule

// File: doc/jtvigil_pcm_mc.md
# jtvigil_pcm_mc

Multi-channel PCM sample fetcher for the sound CPU subsystem. Each channel has a CPU-programmed ROM pointer, a manual or automatic step source and a latched output sample. A single shared PCM ROM port is arbitrated round-robin. It replaces the single-channel write-to-advance PCM logic and feeds per-channel samples to the DC remover and mixer.

## Interface
- CH, 2, number of channels, 1..4
- AW, 16, ROM address width per channel pointer
- DW, 8, sample width
- END_CODE, 8'h80, sample value that stops a channel when its stop-on-end bit is set (compared on low 8 bits)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  sample-rate tick for automatic stepping
- cpu_wr  in  1  register write strobe (may be held several cycles)
- cpu_rd  in  1  sample read strobe
- cpu_addr  in  clog2(CH)+2  {channel, reg}; reg 0 ptr low, 1 ptr high, 2 control, 3 step
- cpu_din  in  8  write data
- cpu_dout  out  DW  registered: selected channel's last sample
- rom_cs  out  1  ROM request
- rom_addr  out  AW  ROM address
- rom_data  in  DW  ROM data
- rom_ok  in  1  ROM data valid for the presented address
- snd_ch  out  CH*DW  latched samples, channel 0 in LSBs
- sample  out  CH  one-cycle pulse per channel on new sample
- running  out  CH  control run bit per channel

## Operation
- Registers per channel: ptr[AW-1:0], ctl[7:0] (bit0 run, bit1 auto, bit2 stop-on-end, bits7:4 rate), pend, prescaler[3:0], sample reg.
- Writes are edge-detected on cpu_wr: one register action per strobe rising edge. Reg 0 writes ptr[7:0]; reg 1 writes ptr[AW-1:8] (upper bits beyond cpu_din zero-filled). Reg 2 writes ctl and clears prescaler. Reg 3 sets pend if run=1 and auto=0; ignored otherwise.
- Auto mode (run=1, auto=1): each cen increments prescaler; when prescaler==rate it clears and pend is set. Step every rate+1 cen ticks.
- A step while pend=1 coalesces (no queue).
- Fetch FSM: IDLE -> REQ -> WAIT -> IDLE.
  - IDLE: if any pend, select first pending channel at or after rr pointer; rr <= sel+1 mod CH; latch sel; go REQ.
  - REQ: rom_cs=1, rom_addr=ptr[sel]; rom_ok ignored this cycle (stale data); go WAIT.
  - WAIT: rom_cs=1; on rom_ok capture. If stop-on-end and data==END_CODE: clear run, no sample pulse, sample reg unchanged, ptr unchanged. Else sample reg <= rom_data, sample[sel] pulses, ptr <= ptr+1 modulo 2^AW. Clear pend[sel]; go IDLE.
- CPU write to ptr of sel during REQ/WAIT: write wins; post-capture increment suppressed; captured data still delivered.
- Control write with run=0 clears pend; an in-flight fetch for that channel completes and delivers its sample.
- cpu_dout updates the cycle after cpu_rd with selected channel's sample reg.

## Timing
- Reset: all ptr, ctl, pend, prescaler, sample regs, snd_ch, cpu_dout = 0; sample=0; rom_cs=0; rom_addr=0; running=0; FSM IDLE; rr=0.
- rom_addr holds last value in IDLE; rom_cs=0 in IDLE.
- Step write edge at cycle T: pend at T+1, REQ at T+2, earliest capture at T+3 (rom_ok high), snd_ch and sample pulse valid at T+4.
- Fetch throughput: one sample per 3 cycles minimum across all channels.
- Simultaneous step and same-channel capture: pend clears after capture, the new step is kept (pend remains 1).

## Test plan
- Reset release, no activity -> all outputs 0, rom_cs never asserted.
- ch0 ptr=0x1234, ctl=0x01, step write, rom_ok tied high, rom_data=0x5A -> rom_addr=0x1234 in REQ/WAIT, snd_ch[7:0]=0x5A with sample[0] at T+4, ptr=0x1235.
- ch0 ptr=0xFFFF, two steps -> second fetch at 0x0000.
- CH=2, both auto, rate=0, cen every cycle -> fetches alternate ch0/ch1, each channel's samples arrive in ptr order, none starved.
- ctl=0x05, data at ptr=0x80 -> running[0] falls, no sample pulse, ptr stays at the end-marker address.
- rom_ok held low 10 cycles in WAIT, ptr low write mid-fetch -> sample delivered when rom_ok rises, ptr equals written value, not incremented.
